hub75_bcm_scan: RTL

- Parametrised HUB75 panel scan engine; next generation after the fixed single-colour turn-on driver.
- Reads packed pixel pairs (upper and lower half) from a framebuffer read port and shifts one bit plane per row into the panel.
- Latches each plane and shows it with binary-coded-modulation (BCM) weighted nOE time, giving 2^BCM_BITS levels per colour.
- Sits between the framebuffer RAM and the panel pins.

---
 rtl/hub75_pkg.sv | 34 +++
 rtl/hub75_bcm_timer.sv | 64 ++++++
 rtl/hub75_bcm_scan.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/hub75_pkg.sv
// hub75_pkg: shared state encoding, fb_data field layout and width helper
// for the HUB75 BCM scan engine.
package hub75_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_CLK_HI  = 3'd3,
        ST_LATCH   = 3'd4,
        ST_DISPLAY = 3'd5,
        ST_ADVANCE = 3'd6
    } state_t;

    // Field index inside fb_data; field i occupies bits [i*BCM_BITS +: BCM_BITS].
    localparam int FIELD_R0   = 0;
    localparam int FIELD_G0   = 1;
    localparam int FIELD_B0   = 2;
    localparam int FIELD_R1   = 3;
    localparam int FIELD_G1   = 4;
    localparam int FIELD_B1   = 5;
    localparam int NUM_FIELDS = 6;

    // Ceiling log2, never less than 1 so it can size a vector directly.
    function automatic int log2_ceil(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// hub75_bcm_timer: loadable down-counter timing one BCM display window.
// Optional HUB75_BRIGHTNESS_EN adds a brightness-scaled on-window compare.
module hub75_bcm_timer #(
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic          run_i,
    input  logic [TW-1:0] load_val_i,
`ifdef HUB75_BRIGHTNESS_EN
    input  logic [7:0]    brightness_i,
`endif
    output logic          done_o,
    output logic          on_o
);

    logic [TW-1:0] cnt_q, cnt_d;

    // Remaining-cycle counter: loaded with the window length, terminal count is 1.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)     cnt_d = load_val_i;
        else if (run_i) cnt_d = cnt_q - TW'(1);
    end

    assign done_o = (cnt_q == TW'(1));

`ifdef HUB75_BRIGHTNESS_EN
    logic [TW+7:0] prod;
    logic [TW-1:0] on_len;
    logic [TW-1:0] off_q, off_d;

    // The window is lit while the remaining count is above off_q, i.e. for
    // the first (load_val*brightness)>>8 cycles; total length is unchanged.
    always_comb begin
        prod   = {8'd0, load_val_i} * {{TW{1'b0}}, brightness_i};
        on_len = TW'(prod >> 8);
        off_d  = load_i ? (load_val_i - on_len) : off_q;
    end

    // Counter and off-threshold registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            off_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            off_q <= off_d;
        end
    end

    assign on_o = (cnt_q > off_q);
`else
    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign on_o = 1'b1;
`endif

endmodule

// File: rtl/hub75_bcm_scan.sv
// hub75_bcm_scan: HUB75 panel scan engine with binary-coded-modulation planes.
// Optional HUB75_BRIGHTNESS_EN adds a global brightness input.
//
//  state      | meaning
//  IDLE       | panel dark, waiting for enable
//  FETCH      | read column 0 of the current row
//  LOAD       | capture current plane bit of each colour field
//  CLK_HI     | shift clock high; prefetch next column
//  LATCH      | latch shifted plane, present row address
//  DISPLAY    | nOE window of BASE_ON<<plane cycles
//  ADVANCE    | step plane / row, decide continue or stop
//
// Every panel pin is a register loaded from the current state's action, so
// pins trail the state by one cycle. The framebuffer request leads instead:
// it is loaded from the state being entered, which puts returning data in
// front of LOAD and puts colour data one cycle ahead of each S_CLK rise.
module hub75_bcm_scan
    import hub75_pkg::*;
#(
    parameter int COLS       = 64,
    parameter int ROW_ADDR_W = 5,
    parameter int BCM_BITS   = 4,
    parameter int BASE_ON    = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  enable,
`ifdef HUB75_BRIGHTNESS_EN
    input  logic [7:0]                            brightness,
`endif
    output logic [ROW_ADDR_W+log2_ceil(COLS)-1:0] fb_addr,
    output logic                                  fb_rd,
    input  logic [NUM_FIELDS*BCM_BITS-1:0]        fb_data,
    output logic [ROW_ADDR_W-1:0]                 row_addr,
    output logic                                  R0,
    output logic                                  G0,
    output logic                                  B0,
    output logic                                  R1,
    output logic                                  G1,
    output logic                                  B1,
    output logic                                  S_CLK,
    output logic                                  LATCH,
    output logic                                  nOE,
    output logic                                  frame_done
);

    localparam int COL_W   = log2_ceil(COLS);
    localparam int PLANE_W = log2_ceil(BCM_BITS);
    localparam int TW      = log2_ceil((BASE_ON << (BCM_BITS - 1)) + 1);
    localparam int AW      = ROW_ADDR_W + COL_W;

    state_t                  state_q, state_d;
    logic [ROW_ADDR_W-1:0]   row_q, row_d, row_addr_q, row_addr_d;
    logic [PLANE_W-1:0]      plane_q, plane_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [AW-1:0]           fb_addr_q, fb_addr_d;
    logic [NUM_FIELDS-1:0]   colour_q, colour_d, plane_bits;
    logic                    fb_rd_q, fb_rd_d, sclk_q, sclk_d, latch_q, latch_d;
    logic                    noe_q, noe_d, fd_q, fd_d, en_q;
    logic                    last_col, last_plane, frame_end, tmr_done, tmr_on;
    logic [TW-1:0]           load_val;

    assign last_col   = (col_q == COL_W'(COLS - 1));
    assign last_plane = (plane_q == PLANE_W'(BCM_BITS - 1));
    assign frame_end  = last_plane && (&row_q);
    assign load_val   = TW'(BASE_ON) << plane_q;

    for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_field
        logic [BCM_BITS-1:0] fld;
        assign fld           = fb_data[g*BCM_BITS +: BCM_BITS];
        assign plane_bits[g] = fld[plane_q];
    end

    hub75_bcm_timer #(.TW(TW)) u_timer (
        .clk          (clk),
        .reset        (reset),
        .load_i       (state_q == ST_LATCH),
        .run_i        (state_q == ST_DISPLAY),
        .load_val_i   (load_val),
`ifdef HUB75_BRIGHTNESS_EN
        .brightness_i (brightness),
`endif
        .done_o       (tmr_done),
        .on_o         (tmr_on)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (en_q) state_d = ST_FETCH;
            ST_FETCH:   state_d = ST_LOAD;
            ST_LOAD:    state_d = ST_CLK_HI;
            ST_CLK_HI:  state_d = last_col ? ST_LATCH : ST_LOAD;
            ST_LATCH:   state_d = ST_DISPLAY;
            ST_DISPLAY: if (tmr_done) state_d = ST_ADVANCE;
            ST_ADVANCE: state_d = (frame_end && !en_q) ? ST_IDLE : ST_FETCH;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output and counter next values for the current state.
    always_comb begin
        row_d      = row_q;
        plane_d    = plane_q;
        col_d      = col_q;
        fb_addr_d  = fb_addr_q;
        fb_rd_d    = 1'b0;
        colour_d   = colour_q;
        sclk_d     = 1'b0;
        latch_d    = 1'b0;
        noe_d      = 1'b1;
        fd_d       = 1'b0;
        row_addr_d = row_addr_q;
        case (state_q)
            ST_FETCH:   col_d = '0;
            ST_LOAD:    colour_d = plane_bits;
            ST_CLK_HI: begin
                sclk_d = 1'b1;
                if (!last_col) col_d = col_q + COL_W'(1);
            end
            ST_LATCH: begin
                latch_d    = 1'b1;
                row_addr_d = row_q;
            end
            ST_DISPLAY: noe_d = !tmr_on;
            ST_ADVANCE: begin
                fd_d = frame_end;
                if (last_plane) begin
                    plane_d = '0;
                    row_d   = row_q + ROW_ADDR_W'(1);
                end else begin
                    plane_d = plane_q + PLANE_W'(1);
                end
            end
            default: ;
        endcase
        if (state_d == ST_FETCH) begin
            fb_rd_d   = 1'b1;
            fb_addr_d = {row_d, {COL_W{1'b0}}};
        end else if (state_q == ST_LOAD && !last_col) begin
            fb_rd_d   = 1'b1;
            fb_addr_d = {row_q, col_q + COL_W'(1)};
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_q      <= '0;
            plane_q    <= '0;
            col_q      <= '0;
            fb_addr_q  <= '0;
            fb_rd_q    <= 1'b0;
            colour_q   <= '0;
            sclk_q     <= 1'b0;
            latch_q    <= 1'b0;
            noe_q      <= 1'b1;
            fd_q       <= 1'b0;
            row_addr_q <= '0;
            en_q       <= 1'b0;
        end else begin
            row_q      <= row_d;
            plane_q    <= plane_d;
            col_q      <= col_d;
            fb_addr_q  <= fb_addr_d;
            fb_rd_q    <= fb_rd_d;
            colour_q   <= colour_d;
            sclk_q     <= sclk_d;
            latch_q    <= latch_d;
            noe_q      <= noe_d;
            fd_q       <= fd_d;
            row_addr_q <= row_addr_d;
            en_q       <= enable;
        end
    end

    assign fb_addr    = fb_addr_q;
    assign fb_rd      = fb_rd_q;
    assign row_addr   = row_addr_q;
    assign R0         = colour_q[FIELD_R0];
    assign G0         = colour_q[FIELD_G0];
    assign B0         = colour_q[FIELD_B0];
    assign R1         = colour_q[FIELD_R1];
    assign G1         = colour_q[FIELD_G1];
    assign B1         = colour_q[FIELD_B1];
    assign S_CLK      = sclk_q;
    assign LATCH      = latch_q;
    assign nOE        = noe_q;
    assign frame_done = fd_q;

endmodule
